port_reset_sequencer: RTL
=========================

Name: port_reset_sequencer

Overview:
Per-port soft-reset controller for the port gasket, generalising the fixed two-flop port reset pipeline to N ports. Each port's reset request is synchronised, the AFU is asked to drain, and the port is held in reset for a guaranteed minimum time. The port leaves reset only after the request is released. It sits between the FME/port-control reset requests and the host-channel mapping and PIM clocking logic, and drives each port's soft reset.

Parameters:
PG_NUM_PORTS, 1, number of AFU ports sequenced independently
SYNC_STAGES, 2, synchroniser depth on port_rst_n (legal 2..4)
MIN_HOLD_CYCLES, 16, minimum clk cycles port_softreset_n is held low (legal 1..65535)
QUIESCE_TIMEOUT, 1024, maximum cycles spent waiting for port_idle; 0 = skip the quiesce phase
CNT_W, derived $clog2(max(MIN_HOLD_CYCLES,QUIESCE_TIMEOUT)+1), shared timer width; localparam only

Ports:
clk  in  1  the port clock; all logic in this domain
rst_n  in  1  global reset; one clock; reset is asynchronous and active-low
port_rst_n  in  PG_NUM_PORTS  per-port reset request, active-low, asynchronous to clk
port_idle  in  PG_NUM_PORTS  AFU reports no outstanding TX/RX traffic on the port
timeout_clr  in  PG_NUM_PORTS  one-cycle pulse that clears the matching quiesce_timeout bit
port_softreset_n  out  PG_NUM_PORTS  soft reset to the AFU port and host-channel map, active-low
drain_req  out  PG_NUM_PORTS  asks the AFU to stop issuing and drain
port_rst_ack  out  PG_NUM_PORTS  high while the port is held in reset
quiesce_timeout  out  PG_NUM_PORTS  sticky flag: the last quiesce ended by timeout

Behaviour:
- All outputs are registered. Ports are fully independent, each with its own FSM, timer and synchroniser.
- On rst_n low (asynchronous): synchroniser flops = 0, state = HOLD, timer = 0, port_softreset_n = 0, drain_req = 0, port_rst_ack = 1, quiesce_timeout = 0.
- Let req = NOT (synchronised port_rst_n). The synchronised value is valid SYNC_STAGES clocks after the input changes.
- State RUN:
  - Outputs: softreset_n = 1, ack = 0, drain_req = 0.
  - If req = 1: go to QUIESCE (or directly to HOLD if QUIESCE_TIMEOUT = 0), timer cleared.
  - drain_req rises SYNC_STAGES+1 clocks after port_rst_n falls.
- State QUIESCE:
  - Outputs: drain_req = 1, softreset_n = 1.
  - Timer increments every cycle.
  - If port_idle = 1 (sampled this cycle): go to HOLD.
  - Else if timer = QUIESCE_TIMEOUT-1: go to HOLD and set quiesce_timeout. If port_idle and the timeout coincide, idle wins and the flag is not set.
  - Deassertion of req during QUIESCE does not abort; the reset always completes.
- State HOLD:
  - Outputs: softreset_n = 0, ack = 1, drain_req = 0.
  - Timer restarts at 0 on entry and saturates at MIN_HOLD_CYCLES.
  - Exit to RUN when timer >= MIN_HOLD_CYCLES-1 AND req = 0. Otherwise remain in HOLD, holding reset indefinitely while req stays asserted.
  - port_softreset_n is low for at least MIN_HOLD_CYCLES consecutive cycles.
- After rst_n rises with port_rst_n already high: port_softreset_n rises at cycle MIN_HOLD_CYCLES (HOLD-timer path; the synchroniser output is already 0 from reset).
- quiesce_timeout: set has priority over a simultaneous timeout_clr. Clearing has no effect on the FSM.
- rst_n asserted mid-QUIESCE or mid-HOLD: immediate async return to reset values; timers restart.
- Timer arithmetic: unsigned CNT_W bits, never wraps; saturates at its terminal count.

Decomposition:
- Package port_reset_seq_pkg:
  - state enum t_prs_state {PRS_RUN, PRS_QUIESCE, PRS_HOLD}, 2 bits
  - function computing CNT_W
- Sub-module port_reset_seq_ch: one port's synchroniser, FSM and timer, with the same parameters minus PG_NUM_PORTS.
- Top level: generate loop instantiating port_reset_seq_ch PG_NUM_PORTS times, plus the sticky-flag registers.

Test Plan:
- Power-up: rst_n low 5 cycles, then high; port_rst_n = 1, MIN_HOLD = 16 -> port_softreset_n = 0, ack = 1 for exactly 16 cycles after release, then softreset_n = 1, ack = 0.
- Clean reset: port_rst_n low 40 cycles, port_idle = 1 -> drain_req one cycle at SYNC_STAGES+1, then HOLD. softreset_n low until 16 cycles have elapsed and the synchronised request has released. No timeout flag.
- Timeout: QUIESCE_TIMEOUT = 8, port_idle = 0 -> drain_req high exactly 8 cycles, quiesce_timeout = 1. A timeout_clr pulse clears it. A timeout_clr in the same cycle as a new timeout leaves it at 1.
- Short request: port_rst_n low for 3 cycles only -> reset still completes, softreset_n low exactly 16 cycles.
- Multi-port, PG_NUM_PORTS = 4: reset port 2 only -> ports 0, 1, 3 keep softreset_n = 1, drain_req = 0 throughout.
- Async abort: rst_n low during QUIESCE cycle 3 -> outputs reach reset values in the same cycle without a clock edge. After release, the port follows the power-up sequence.

Source files
------------

// File: rtl/port_reset_seq_pkg.sv
// Shared types and helpers for the per-port soft-reset sequencer.
// The timer width covers the longer of the hold and quiesce budgets.
package port_reset_seq_pkg;

  typedef enum logic [1:0] {
    PRS_RUN     = 2'd0,
    PRS_QUIESCE = 2'd1,
    PRS_HOLD    = 2'd2
  } t_prs_state;

  function automatic int prs_cnt_w(input int min_hold, input int quiesce_to);
    int m;
    m = (min_hold > quiesce_to) ? min_hold : quiesce_to;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/port_reset_sequencer_if.sv
// Per-port reset request / drain / soft-reset bundle between the port
// control block (master) and the reset sequencer (slave).
interface port_reset_sequencer_if #(
  parameter int PG_NUM_PORTS = 1
) ();

  logic [PG_NUM_PORTS-1:0] port_rst_n;
  logic [PG_NUM_PORTS-1:0] port_idle;
  logic [PG_NUM_PORTS-1:0] timeout_clr;
  logic [PG_NUM_PORTS-1:0] port_softreset_n;
  logic [PG_NUM_PORTS-1:0] drain_req;
  logic [PG_NUM_PORTS-1:0] port_rst_ack;
  logic [PG_NUM_PORTS-1:0] quiesce_timeout;

  modport master (
    output port_rst_n, port_idle, timeout_clr,
    input  port_softreset_n, drain_req, port_rst_ack, quiesce_timeout
  );

  modport slave (
    input  port_rst_n, port_idle, timeout_clr,
    output port_softreset_n, drain_req, port_rst_ack, quiesce_timeout
  );

endinterface

// File: rtl/port_reset_seq_ch.sv
// One port: request synchroniser, RUN/QUIESCE/HOLD sequencer and shared timer.
// Outputs are registered from the next state so they change with the state.
module port_reset_seq_ch
  import port_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int MIN_HOLD_CYCLES = 16,
  parameter int QUIESCE_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_port_rst_n,
  input  logic i_port_idle,
  output logic o_softreset_n,
  output logic o_drain_req,
  output logic o_rst_ack,
  output logic o_timeout_set
);

  localparam int CNT_W = prs_cnt_w(MIN_HOLD_CYCLES, QUIESCE_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MIN_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] QTO_LAST  =
    CNT_W'((QUIESCE_TIMEOUT > 0) ? (QUIESCE_TIMEOUT - 1) : 0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req;
  t_prs_state             r_state, w_nxt_state;
  logic [CNT_W-1:0]       r_timer, w_nxt_timer;
  logic                   w_timeout;
  logic                   w_softreset_n, w_drain_req, w_rst_ack;
  logic                   r_softreset_n, r_drain_req, r_rst_ack;

  // Flops clear to 0, so the port looks requested until the input propagates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_port_rst_n};
  end

  assign w_req = ~r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= PRS_HOLD;
      r_timer       <= '0;
      r_softreset_n <= 1'b0;
      r_drain_req   <= 1'b0;
      r_rst_ack     <= 1'b1;
    end else begin
      r_state       <= w_nxt_state;
      r_timer       <= w_nxt_timer;
      r_softreset_n <= w_softreset_n;
      r_drain_req   <= w_drain_req;
      r_rst_ack     <= w_rst_ack;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_timer = r_timer;
    w_timeout   = 1'b0;
    case (r_state)
      PRS_RUN: begin
        w_nxt_timer = '0;
        if (w_req) w_nxt_state = (QUIESCE_TIMEOUT == 0) ? PRS_HOLD : PRS_QUIESCE;
      end
      PRS_QUIESCE: begin
        if (r_timer != QTO_LAST) w_nxt_timer = r_timer + 1'b1;
        // Idle wins over a coinciding timeout; a dropped request never aborts.
        if (i_port_idle) begin
          w_nxt_state = PRS_HOLD;
          w_nxt_timer = '0;
        end else if (r_timer == QTO_LAST) begin
          w_nxt_state = PRS_HOLD;
          w_nxt_timer = '0;
          w_timeout   = 1'b1;
        end
      end
      PRS_HOLD: begin
        if (r_timer < HOLD_MAX) w_nxt_timer = r_timer + 1'b1;
        if ((r_timer >= HOLD_LAST) && !w_req) begin
          w_nxt_state = PRS_RUN;
          w_nxt_timer = '0;
        end
      end
      default: begin
        w_nxt_state = PRS_HOLD;
        w_nxt_timer = '0;
      end
    endcase
  end

  always_comb begin
    w_softreset_n = (w_nxt_state != PRS_HOLD);
    w_rst_ack     = (w_nxt_state == PRS_HOLD);
    w_drain_req   = (w_nxt_state == PRS_QUIESCE);
  end

  assign o_softreset_n = r_softreset_n;
  assign o_drain_req   = r_drain_req;
  assign o_rst_ack     = r_rst_ack;
  assign o_timeout_set = w_timeout;

endmodule

// File: rtl/port_reset_sequencer.sv
// N independent port soft-reset sequencers plus the sticky quiesce-timeout flags.
// A timeout being recorded beats a clear pulse arriving in the same cycle.
module port_reset_sequencer
  import port_reset_seq_pkg::*;
#(
  parameter int PG_NUM_PORTS    = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int MIN_HOLD_CYCLES = 16,
  parameter int QUIESCE_TIMEOUT = 1024
) (
  input logic                   clk,
  input logic                   rst_n,
  port_reset_sequencer_if.slave prs_if
);

  logic [PG_NUM_PORTS-1:0] w_softreset_n;
  logic [PG_NUM_PORTS-1:0] w_drain_req;
  logic [PG_NUM_PORTS-1:0] w_rst_ack;
  logic [PG_NUM_PORTS-1:0] w_timeout_set;
  logic [PG_NUM_PORTS-1:0] r_quiesce_timeout;

  for (genvar g = 0; g < PG_NUM_PORTS; g++) begin : g_port
    port_reset_seq_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .MIN_HOLD_CYCLES(MIN_HOLD_CYCLES),
      .QUIESCE_TIMEOUT(QUIESCE_TIMEOUT)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_port_rst_n (prs_if.port_rst_n[g]),
      .i_port_idle  (prs_if.port_idle[g]),
      .o_softreset_n(w_softreset_n[g]),
      .o_drain_req  (w_drain_req[g]),
      .o_rst_ack    (w_rst_ack[g]),
      .o_timeout_set(w_timeout_set[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_quiesce_timeout <= '0;
    else        r_quiesce_timeout <= w_timeout_set | (r_quiesce_timeout & ~prs_if.timeout_clr);
  end

  assign prs_if.port_softreset_n = w_softreset_n;
  assign prs_if.drain_req        = w_drain_req;
  assign prs_if.port_rst_ack     = w_rst_ack;
  assign prs_if.quiesce_timeout  = r_quiesce_timeout;

endmodule
